// File: rtl/instr_prefetch_queue_if.sv
// Prefetch queue bus: instruction-memory req/ack handshake plus the head-of-queue port to IF_ID.
// master = the prefetch queue, slave = memory and the IF_ID consumer.
interface instr_prefetch_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_data;
  logic              deq;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pcplus4;
  logic [CntW-1:0]   count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pcplus4, count,
    input  imem_ack, imem_data, deq
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pcplus4, count,
    output imem_ack, imem_data, deq
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch via req/ack into a FIFO of {instr, PC+4} pairs.
// Optional same-cycle empty-FIFO bypass from memory to the head: define PREFETCH_BYPASS_EN.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      start_pc,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  instr_prefetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]   Full = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] Four = ADDR_W'(4);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("instr_prefetch_queue: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc4_q   [DEPTH];

  logic              live_ack;
  logic              fifo_empty;
  logic              bypass_take;
  logic              enq;
  logic              pop;
  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4   = fetch_pc_q + Four;
  // Acks are only meaningful while a live request is outstanding.
  assign live_ack   = (state_q == StWait) & bus.imem_ack;
  assign fifo_empty = (count_q == '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass_take = fifo_empty & live_ack & ~redirect & bus.deq;
`else
  assign bypass_take = 1'b0;
`endif

  assign enq = live_ack & ~redirect & ~bypass_take;
  assign pop = bus.deq & ~fifo_empty & ~redirect;

  // Pointer, count and fetch-address next state; redirect flushes and wins over everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (live_ack) fetch_pc_d = pc_plus4;
      if (enq)      wr_ptr_d   = wr_ptr_q + PtrW'(1);
      if (pop)      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(enq) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= start_pc;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      instr_q[wr_ptr_q] <= bus.imem_data;
      pc4_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  // Request issue decisions use the occupancy after this cycle's enqueue/dequeue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (redirect || count_d < Full) state_d = StWait;
      end
      StWait: begin
        if (redirect) begin
          state_d = bus.imem_ack ? StWait : StDiscard;
        end else if (bus.imem_ack) begin
          state_d = (count_d < Full) ? StWait : StIdle;
        end
      end
      StDiscard: begin
        // The abandoned request completes; fetch_pc already holds the redirect target.
        if (bus.imem_ack) state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == StWait);
    bus.imem_addr   = fetch_pc_q;
    bus.out_valid   = ~fifo_empty;
    bus.out_instr   = instr_q[rd_ptr_q];
    bus.out_pcplus4 = pc4_q[rd_ptr_q];
`ifdef PREFETCH_BYPASS_EN
    if (fifo_empty && live_ack && !redirect) begin
      bus.out_valid   = 1'b1;
      bus.out_instr   = bus.imem_data;
      bus.out_pcplus4 = pc_plus4;
    end
`endif
  end

  assign bus.count = count_q;

  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.imem_req && !bus.imem_ack && !redirect) |=> (bus.imem_req && $stable(bus.imem_addr)));

  a_no_ack_when_full: assert property (@(posedge clk) disable iff (reset)
    live_ack |-> (count_q < Full));
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch queue between instruction memory and the IF_ID pipeline register. It runs ahead of the pipeline: it fetches sequential instructions through a req/ack memory handshake and buffers {instruction, PC+4} pairs in a FIFO. It presents the oldest pair to IF_ID, and flushes and refetches on branch/jump redirects from EXE/ID. It decouples variable-latency instruction memory from the hazard-driven IF_ID_Write stall.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 32, PC and address width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start_pc  input  ADDR_W  fetch address loaded while reset is high
- redirect  input  1  taken branch or jump; flush and refetch
- redirect_pc  input  ADDR_W  new fetch address, valid with redirect
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  ADDR_W  fetch address, word aligned
- imem_ack  input  1  memory returns data this cycle
- imem_data  input  32  instruction word, valid with imem_ack
- deq  input  1  consumer takes head entry (driven by IF_ID_Write)
- out_valid  output  1  head entry valid
- out_instr  output  32  head instruction
- out_pcplus4  output  ADDR_W  head PC+4
- count  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Registers: fetch_pc, FIFO storage, rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count, FSM state.
- FSM states:
  - IDLE: imem_req=0. Go to WAIT when count < DEPTH and redirect=0.
  - WAIT: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack: enqueue {imem_data, fetch_pc+4}; fetch_pc += 4; go to WAIT if count after this cycle < DEPTH, else IDLE.
  - DISCARD: imem_req=0. Waits for the ack of an abandoned request and drops it. Goes to WAIT on that ack.
- Only one request is outstanding at a time. A request is issued only with a free slot, so an ack never arrives when the queue is full.
- Handshake: once raised, imem_req and imem_addr hold stable until imem_ack. The ack is sampled only while a request is outstanding.
- deq with out_valid=0 is ignored. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect has the highest priority. It overrides deq and ack in the same cycle.
  - Flushes the FIFO: count=0, ptrs=0, out_valid=0.
  - Sets fetch_pc=redirect_pc.
  - State after redirect:
    - WAIT without ack that cycle → DISCARD.
    - WAIT with ack that cycle → WAIT (data dropped).
    - IDLE → WAIT.
    - DISCARD → DISCARD (the old request is still pending).
- A redirect during DISCARD updates fetch_pc only.
- fetch_pc arithmetic is modulo 2^ADDR_W; wrap from 0xFFFFFFFC to 0 is legal.

## Timing
- While reset is high:
  - imem_req=0, out_valid=0, count=0, state=IDLE, fetch_pc=start_pc.
  - A pending ack is ignored.
  - Reset mid-transaction abandons the request; memory must tolerate an unacknowledged request being dropped.
- First cycle after reset: IDLE→WAIT. imem_req=1 with imem_addr=start_pc one cycle after reset deasserts.
- Fetch latency: an ack in cycle N makes the entry visible at the head in cycle N+1 (out_valid=1 if the FIFO was empty). The bypass option changes this (see Configuration).
- Throughput: one instruction per cycle when ack returns every cycle. No bubble between consecutive requests while space remains.
- deq in cycle N: the head advances at the N+1 edge, and the next entry appears in cycle N+1.
- Redirect in cycle N: out_valid=0 in N+1. The new request is issued in N+1 unless the FSM is in DISCARD.
- count, out_* are registered. imem_req and imem_addr are decoded from registered state.

## Configuration
- PREFETCH_BYPASS_EN
  - Defined: when the FIFO is empty and imem_ack=1 with no redirect, out_valid=1 and out_instr=imem_data combinationally in the same cycle, with out_pcplus4=fetch_pc+4.
    - If deq is also asserted, the entry is consumed without being written.
    - If deq is not asserted, it is written normally.
  - Undefined: no combinational path from imem_* to out_*; one-cycle fill latency as in Timing.

## Test plan
- Reset with start_pc=320, imem_ack every cycle, deq=0 → imem_addr 320,324,328,332. imem_req drops after the 4th ack, count=4, out_pcplus4=324.
- Full queue at DEPTH=4, then deq one cycle → count 3, a new request for addr 336 is issued next cycle, head out_pcplus4=328.
- redirect to 0x200 in the same cycle as ack and deq → count=0, out_valid=0 next cycle, then imem_addr=0x200, and the acked data never appears.
- redirect to 0x400 while a request for 0x148 is waiting without ack, ack after 3 cycles → that data is dropped, and the next request is for 0x400.
- fetch_pc=0xFFFFFFFC, ack twice → out_pcplus4 values 0x00000000 then 0x00000004, and the second fetch address is 0.
- With PREFETCH_BYPASS_EN, empty FIFO, ack plus deq in the same cycle → out_valid=1 that cycle with out_instr=imem_data, and count stays 0.
